pdm_cic_decimator: RTL

//  - Multi-stage CIC decimator: first filtering stage of the PDM microphone path.
//  - Upstream: PDM capture stage, which supplies one microphone bit per M_CLK period as a 1-cycle pdm_valid strobe.
//  - Downstream: FIR compensation/second decimation stage, which receives signed PCM words at PDM rate / DECIMATION_FACTOR.
//  - Maps bit 1 -> +1 and bit 0 -> -1; N integrators at input rate, N combs at output rate; scales and saturates to DATA_WIDTH.

---
 rtl/pdm_cic_decimator_pkg.sv | 22 ++
 rtl/pdm_cic_decimator_if.sv | 13 +
 rtl/pdm_cic_decimator_comb_stage.sv | 35 +++
 rtl/pdm_cic_decimator.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pdm_cic_decimator_pkg.sv
// rtl/pdm_cic_decimator_pkg.sv - shared widths, helpers and PCM type for the PDM CIC decimator
package pdm_pkg;

    localparam int DEF_DECIMATION_FACTOR = 128;
    localparam int DEF_CIC_STAGES        = 4;
    localparam int DEF_DATA_WIDTH        = 16;

    // Accumulator width: 2-bit signed input plus full CIC bit growth N*log2(R).
    function automatic int cic_width(input int r, input int n);
        return 2 + n * $clog2(r);
    endfunction

    function automatic int cic_shift(input int r, input int n, input int dw);
        return n * $clog2(r) + 1 - dw;
    endfunction

    localparam int W_ACC = cic_width(DEF_DECIMATION_FACTOR, DEF_CIC_STAGES);
    localparam int SHIFT = cic_shift(DEF_DECIMATION_FACTOR, DEF_CIC_STAGES, DEF_DATA_WIDTH);

    typedef logic signed [DEF_DATA_WIDTH-1:0] pcm_t;

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// rtl/pdm_cic_decimator_if.sv - PDM input strobe and PCM output strobe bundle
interface pdm_cic_decimator_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         pdm_bit;
    logic                         pdm_valid;
    logic signed [DATA_WIDTH-1:0] pcm_data;
    logic                         pcm_valid;
    logic                         pcm_sat;

    modport master (output pdm_bit, pdm_valid, input pcm_data, pcm_valid, pcm_sat);
    modport slave  (input pdm_bit, pdm_valid, output pcm_data, pcm_valid, pcm_sat);
endinterface

// File: rtl/pdm_cic_decimator_comb_stage.sv
// rtl/pdm_cic_decimator_comb_stage.sv - one CIC comb stage, differential delay 1, registered output
module cic_comb_stage #(
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] y_q, y_d;

    always_comb begin
        d_d = d_q;
        y_d = y_q;
        if (en) begin
            y_d = x - d_q;
            d_d = x;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
            y_q <= '0;
        end else begin
            d_q <= d_d;
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - N-stage CIC decimator turning a PDM bitstream into saturated signed PCM
module pdm_cic_decimator
    import pdm_pkg::*;
#(
    parameter int DECIMATION_FACTOR = DEF_DECIMATION_FACTOR,
    parameter int CIC_STAGES        = DEF_CIC_STAGES,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    pdm_cic_decimator_if.slave     bus
);
    localparam int N      = CIC_STAGES;
    localparam int LOG2R  = $clog2(DECIMATION_FACTOR);
    localparam int WA     = cic_width(DECIMATION_FACTOR, CIC_STAGES);
    localparam int SH     = cic_shift(DECIMATION_FACTOR, CIC_STAGES, DATA_WIDTH);
    localparam int WARM_W = $clog2(N + 1);

    localparam logic signed [WA-1:0] PCM_MAX = WA'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [WA-1:0] PCM_MIN = ~PCM_MAX;

    if ((1 << LOG2R) != DECIMATION_FACTOR) begin : g_chk_pow2
        $error("DECIMATION_FACTOR must be a power of two");
    end
    if (DECIMATION_FACTOR < N + 2) begin : g_chk_overlap
        $error("DECIMATION_FACTOR must be at least CIC_STAGES+2");
    end
    if (SH < 0) begin : g_chk_shift
        $error("output shift must be non-negative");
    end

    logic [WA-1:0]         integ_q [N];
    logic [WA-1:0]         integ_d [N];
    logic [LOG2R-1:0]      cnt_q, cnt_d;
    logic [N:0]            vld_q, vld_d;
    logic [WARM_W-1:0]     warm_q, warm_d;
    logic [DATA_WIDTH-1:0] pcm_data_q, pcm_data_d;
    logic                  pcm_valid_q, pcm_valid_d;
    logic                  pcm_sat_q, pcm_sat_d;

    logic [WA-1:0]         comb_x [N];
    logic [WA-1:0]         comb_y [N];
    logic [WA-1:0]         in_term;
    logic signed [WA-1:0]  y_shift;
    logic                  clip;

    for (genvar k = 0; k < N; k++) begin : g_comb
        if (k == 0) begin : g_first
            assign comb_x[k] = integ_q[N-1];
        end else begin : g_rest
            assign comb_x[k] = comb_y[k-1];
        end
        cic_comb_stage #(.WIDTH(WA)) u_comb (
            .clk (clk),
            .rst (rst),
            .en  (vld_q[k]),
            .x   (comb_x[k]),
            .y   (comb_y[k])
        );
    end

    always_comb begin
        in_term     = bus.pdm_bit ? WA'(1) : {WA{1'b1}};
        integ_d     = integ_q;
        cnt_d       = cnt_q;
        warm_d      = warm_q;
        pcm_data_d  = pcm_data_q;
        pcm_valid_d = 1'b0;
        pcm_sat_d   = 1'b0;

        if (bus.pdm_valid) begin
            integ_d[0] = integ_q[0] + in_term;
            for (int k = 1; k < N; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            cnt_d = cnt_q + LOG2R'(1);
        end

        // vld_q[k] enables comb stage k; vld_q[N] registers the output word.
        vld_d = {vld_q[N-1:0], bus.pdm_valid && (cnt_q == LOG2R'(DECIMATION_FACTOR - 1))};

        y_shift = $signed(comb_y[N-1]) >>> SH;
        clip    = (y_shift > PCM_MAX) || (y_shift < PCM_MIN);

        if (vld_q[N]) begin
            if (y_shift > PCM_MAX) begin
                pcm_data_d = PCM_MAX[DATA_WIDTH-1:0];
            end else if (y_shift < PCM_MIN) begin
                pcm_data_d = PCM_MIN[DATA_WIDTH-1:0];
            end else begin
                pcm_data_d = y_shift[DATA_WIDTH-1:0];
            end
            // The first N words still carry start-up transient from the zeroed comb delays.
            if (warm_q == WARM_W'(N)) begin
                pcm_valid_d = 1'b1;
                pcm_sat_d   = clip;
            end else begin
                warm_d = warm_q + WARM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
            end
            cnt_q       <= '0;
            vld_q       <= '0;
            warm_q      <= '0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            pcm_sat_q   <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            warm_q      <= warm_d;
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
            pcm_sat_q   <= pcm_sat_d;
        end
    end

    assign bus.pcm_data  = pcm_data_q;
    assign bus.pcm_valid = pcm_valid_q;
    assign bus.pcm_sat   = pcm_sat_q;

endmodule
